note_window: RTL and testbench
==============================

Name: note_window

Overview:
- Upstream feeder for the note display stage: maintains the array of displayable (note, ran_for, duration) triples that the display renderer consumes.
- Reads a sorted song ROM and admits each note when it reaches the window's leading edge. Ages every live note on each beat48 tick and retires notes once they have scrolled off screen.
- Sits between the song ROM / beat48 tick generator and the display renderer.

Parameters:
- DISPLAYED_BEATS, 8, beats visible on screen
- SIMULTANEOUS_NOTES, 2, notes displayable at once per beat
- BEAT_DURATION, 48, beat48 ticks per beat
- BEAT_BITS, 11, width of beat/ran_for/duration fields
- NOTE_BITS, 6, width of note field; all-ones = end-of-song marker
- ROM_ADDR_BITS, 10, song ROM address width
- Derived: SLOTS = 2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES; LOOKAHEAD = (DISPLAYED_BEATS>>1)*BEAT_DURATION; RETIRE = DISPLAYED_BEATS*BEAT_DURATION; ENTRY_BITS = NOTE_BITS+2*BEAT_BITS

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: restart song from ROM address 0
- beat_tick  in  1  one-cycle pulse per beat48
- rom_addr  out  ROM_ADDR_BITS  song ROM read address
- rom_data  in  ENTRY_BITS  {note, start_beat, duration}; synchronous ROM, 1-cycle latency
- notes  out  [NOTE_BITS+2*BEAT_BITS-1:0] x SLOTS  per slot {note, ran_for, duration}, unpacked array
- song_done  out  1  end marker reached; held until start
- overflow  out  1  sticky: entry dropped (no free slot) or tick missed; cleared by start

Behaviour:
- Reset (async, reset_n=0): state IDLE, song_beat=0, ptr=0, all slots invalid, song_done=0, overflow=0, pending=0, rom_addr=0.
- Invalid slot drives all-zero triple. Internal per-slot valid bit.
- rom_addr = ptr combinationally. rom_data is valid the cycle after ptr is stable.
- FSM states:
  - IDLE: start has priority. start -> clear slots/ptr/song_beat/flags, go WAIT. Else (beat_tick or pending) and !song_done -> AGE, clear pending.
  - AGE (1 cycle): song_beat+1. Each valid slot ran_for+1. Retire a slot when the new ran_for >= duration+RETIRE. Go WAIT.
  - WAIT (1 cycle): ROM latency. Go CHECK.
  - CHECK:
    - note==all-ones: song_done=1, go IDLE.
    - Else if start_beat <= song_beat+LOOKAHEAD: the entry is due. Write it to the lowest-index free slot with ran_for = song_beat+LOOKAHEAD-start_beat. Then ptr+1 and go WAIT.
    - If no slot is free: set overflow, drop the entry, still ptr+1 and go WAIT.
    - Else (entry not yet due): go IDLE; ptr unchanged.
- Retire in AGE precedes admission in CHECK, so a slot freed on a tick is reusable on that same tick.
- beat_tick while not IDLE: set pending. beat_tick while pending already set: set overflow; that tick is lost.
- A start pulse in any state aborts the current operation, performs the IDLE start action the next cycle, and discards pending.
- Arithmetic: do all comparisons and sums at BEAT_BITS+1 bits to avoid wrap. ran_for saturates at all-ones.
- ptr wraps at 2^ROM_ADDR_BITS. The ROM must contain an end marker.
- Aging stops after song_done. Remaining notes freeze.

Test Plan:
- Reset mid-song (reset_n low 1 cycle) -> all notes zero, song_done=0, overflow=0, rom_addr=0 asynchronously.
- ROM {5,0,48},{7,48,24},end; start -> after WAIT/CHECK, slot0={5,192,48}, where ran_for = 0+192-0 with LOOKAHEAD=192. Entry 1 is due at start_beat 48 <= 192, so slot1={7,144,24}. Then song_done=1.
- ROM {3,300,10},end; start, then 108 ticks -> slot0 stays invalid until tick 108, then {3,0,10}. After 394 more ticks the note retires (ran_for reaches 10+384); slot0 returns to zeros.
- 33 entries all start_beat=0 with SLOTS=32; start -> slots 0..31 filled in ascending index, entry 33 dropped, overflow=1, ptr=33.
- Two beat_tick pulses during one WAIT/CHECK burst -> first tick serviced after return to IDLE, second tick lost, overflow=1.
- start pulse while in CHECK with 3 live slots -> next cycle all slots zero, ptr=0, song_beat=0, flags cleared, refetch from address 0.

Source files
------------

// File: rtl/note_window.sv
// note_window: keeps the set of on-screen (note, ran_for, duration) triples
// for the display renderer. Notes are pulled from a time-sorted song ROM as
// they reach the leading edge of the window, aged on every beat48 tick and
// retired once they have scrolled off the trailing edge.
module note_window #(
    parameter int DISPLAYED_BEATS    = 8,
    parameter int SIMULTANEOUS_NOTES = 2,
    parameter int BEAT_DURATION      = 48,
    parameter int BEAT_BITS          = 11,
    parameter int NOTE_BITS          = 6,
    parameter int ROM_ADDR_BITS      = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              beat_tick,
    output logic [ROM_ADDR_BITS-1:0]          rom_addr,
    input  logic [NOTE_BITS+2*BEAT_BITS-1:0]  rom_data,
    output logic [NOTE_BITS+2*BEAT_BITS-1:0]  notes [2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES],
    output logic                              song_done,
    output logic                              overflow
);

    localparam int SLOTS      = 2 * DISPLAYED_BEATS * SIMULTANEOUS_NOTES;
    localparam int LOOKAHEAD  = (DISPLAYED_BEATS >> 1) * BEAT_DURATION;
    localparam int RETIRE     = DISPLAYED_BEATS * BEAT_DURATION;
    localparam int ENTRY_BITS = NOTE_BITS + 2 * BEAT_BITS;
    localparam int EXT_BITS   = BEAT_BITS + 1;
    localparam int IDX_BITS   = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    // One extra bit on every beat sum/compare so window arithmetic never wraps.
    localparam logic [EXT_BITS-1:0]  LOOKAHEAD_X = EXT_BITS'(LOOKAHEAD);
    localparam logic [EXT_BITS-1:0]  RETIRE_X    = EXT_BITS'(RETIRE);
    localparam logic [BEAT_BITS-1:0] BEAT_MAX    = '1;
    localparam logic [NOTE_BITS-1:0] END_NOTE    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AGE   = 2'd1,
        S_WAIT  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    // Sequencer state
    state_t                   r_state;
    logic [ROM_ADDR_BITS-1:0] r_ptr;
    logic [BEAT_BITS-1:0]     r_song_beat;
    logic                     r_pending;
    logic                     r_song_done;
    logic                     r_overflow;

    state_t                   w_state_next;
    logic [ROM_ADDR_BITS-1:0] w_ptr_next;
    logic [BEAT_BITS-1:0]     w_song_beat_next;
    logic                     w_pending_next;
    logic                     w_song_done_next;
    logic                     w_overflow_next;

    // Slot control
    logic                     w_age;
    logic                     w_admit_en;
    logic [SLOTS-1:0]         w_free;
    logic                     w_any_free;
    logic [IDX_BITS-1:0]      w_free_idx;

    // Decoded ROM entry and window arithmetic
    logic [ENTRY_BITS-1:0]    w_rom_entry;
    logic [NOTE_BITS-1:0]     w_rom_note;
    logic [BEAT_BITS-1:0]     w_rom_start;
    logic [BEAT_BITS-1:0]     w_rom_dur;
    logic [EXT_BITS-1:0]      w_lead;
    logic [EXT_BITS-1:0]      w_admit_diff;
    logic [BEAT_BITS-1:0]     w_admit_ran;
    logic                     w_is_end;
    logic                     w_due;

    assign w_rom_entry = rom_data;
    assign {w_rom_note, w_rom_start, w_rom_dur} = w_rom_entry;

    assign w_is_end     = (w_rom_note == END_NOTE);
    // Leading edge of the window in song time; an entry at or before it is due.
    assign w_lead       = {1'b0, r_song_beat} + LOOKAHEAD_X;
    assign w_due        = ({1'b0, w_rom_start} <= w_lead);
    assign w_admit_diff = w_lead - {1'b0, w_rom_start};
    assign w_admit_ran  = w_admit_diff[BEAT_BITS] ? BEAT_MAX : w_admit_diff[BEAT_BITS-1:0];

    assign rom_addr  = r_ptr;
    assign song_done = r_song_done;
    assign overflow  = r_overflow;

    // Lowest-index free slot: scan downward so the smallest index wins.
    always_comb begin
        w_free_idx = '0;
        w_any_free = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_free_idx = IDX_BITS'(i);
                w_any_free = 1'b1;
            end
        end
    end

    // Next-state and control decode; start overrides everything else.
    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_song_beat_next = r_song_beat;
        w_pending_next   = r_pending;
        w_song_done_next = r_song_done;
        w_overflow_next  = r_overflow;
        w_age            = 1'b0;
        w_admit_en       = 1'b0;

        if (start) begin
            w_state_next     = S_WAIT;
            w_ptr_next       = '0;
            w_song_beat_next = '0;
            w_pending_next   = 1'b0;
            w_song_done_next = 1'b0;
            w_overflow_next  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((beat_tick || r_pending) && !r_song_done) begin
                        w_state_next   = S_AGE;
                        w_pending_next = 1'b0;
                    end
                end
                S_AGE: begin
                    w_age            = 1'b1;
                    w_song_beat_next = r_song_beat + BEAT_BITS'(1);
                    w_state_next     = S_WAIT;
                end
                S_WAIT: begin
                    w_state_next = S_CHECK;
                end
                S_CHECK: begin
                    if (w_is_end) begin
                        w_song_done_next = 1'b1;
                        w_state_next     = S_IDLE;
                    end else if (w_due) begin
                        // A due entry is consumed even when it has to be dropped.
                        w_ptr_next   = r_ptr + ROM_ADDR_BITS'(1);
                        w_state_next = S_WAIT;
                        if (w_any_free) begin
                            w_admit_en = 1'b1;
                        end else begin
                            w_overflow_next = 1'b1;
                        end
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase

            // Only one tick can be remembered; a second one is lost and flagged.
            if (beat_tick) begin
                if (r_pending) begin
                    w_overflow_next = 1'b1;
                end else if (r_state != S_IDLE) begin
                    w_pending_next = 1'b1;
                end
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_song_beat <= '0;
            r_pending   <= 1'b0;
            r_song_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_song_beat <= w_song_beat_next;
            r_pending   <= w_pending_next;
            r_song_done <= w_song_done_next;
            r_overflow  <= w_overflow_next;
        end
    end

    // Per-slot storage: age/retire in AGE, load in CHECK. The two never overlap,
    // so a slot retired on a tick is free for the admissions that follow it.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic                 r_valid;
        logic [NOTE_BITS-1:0] r_note;
        logic [BEAT_BITS-1:0] r_ran;
        logic [BEAT_BITS-1:0] r_dur;
        logic [BEAT_BITS-1:0] w_ran_inc;
        logic                 w_retire;
        logic                 w_load;

        assign w_ran_inc = (r_ran == BEAT_MAX) ? r_ran : r_ran + BEAT_BITS'(1);
        assign w_retire  = ({1'b0, w_ran_inc} >= ({1'b0, r_dur} + RETIRE_X));
        assign w_load    = w_admit_en && (w_free_idx == IDX_BITS'(gi));

        // Slot update: clear on start, age/retire on tick, fill on admission.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_note  <= '0;
                r_ran   <= '0;
                r_dur   <= '0;
            end else if (start) begin
                r_valid <= 1'b0;
                r_note  <= '0;
                r_ran   <= '0;
                r_dur   <= '0;
            end else if (w_age && r_valid) begin
                r_ran <= w_ran_inc;
                if (w_retire) begin
                    r_valid <= 1'b0;
                end
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_note  <= w_rom_note;
                r_ran   <= w_admit_ran;
                r_dur   <= w_rom_dur;
            end
        end

        assign w_free[gi] = ~r_valid;
        assign notes[gi]  = r_valid ? {r_note, r_ran, r_dur} : '0;
    end

endmodule

// File: tb/tb_note_window.sv
// Bench for note_window: table of single-note scenarios, hand-written
// multi-cycle sequences, and random songs checked against a note-level model.
module tb_note_window;

    localparam int SLOTS = 32;
    localparam int LOOK  = 192;
    localparam int RET   = 384;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        beat_tick = 1'b0;
    logic [9:0]  rom_addr;
    logic [27:0] rom_data;
    logic [27:0] notes [SLOTS];
    logic        song_done;
    logic        overflow;

    logic [27:0] rom_mem [1024];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (note-level, no cycle timing)
    bit m_val  [SLOTS];
    int m_note [SLOTS];
    int m_ran  [SLOTS];
    int m_dur  [SLOTS];
    int m_beat;
    int m_ptr;
    bit m_done;
    bit m_ovf;

    typedef struct {
        int          note;
        int          start_beat;
        int          dur;
        int          ticks;
        logic [27:0] exp0;
    } vec_t;

    vec_t vecs [12];

    note_window dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .beat_tick (beat_tick),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .notes     (notes),
        .song_done (song_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM, one cycle latency
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    function automatic logic [27:0] trip(int n, int r, int d);
        logic [5:0]  fn;
        logic [10:0] fr;
        logic [10:0] fd;
        fn = 6'(n);
        fr = 11'(r);
        fd = 11'(d);
        return {fn, fr, fd};
    endfunction

    task automatic chk(string name, logic [27:0] act, logic [27:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom_mem[i] = 28'hFFF_FFFF;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_tick(int gap);
        @(posedge clk); #1 beat_tick = 1'b1;
        @(posedge clk); #1 beat_tick = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // ---------------- reference model ----------------
    task automatic m_admit(output int consumed);
        logic [27:0] e;
        int          sb;
        int          free;
        consumed = 0;
        for (int guard = 0; guard < 1024; guard++) begin
            e = rom_mem[m_ptr];
            if (e[27:22] == 6'h3F) begin
                m_done = 1'b1;
                break;
            end
            sb = int'(e[21:11]);
            if (sb > m_beat + LOOK) break;
            free = -1;
            for (int s = SLOTS - 1; s >= 0; s--) if (!m_val[s]) free = s;
            if (free < 0) begin
                m_ovf = 1'b1;
            end else begin
                m_val[free]  = 1'b1;
                m_note[free] = int'(e[27:22]);
                m_ran[free]  = (m_beat + LOOK - sb > 2047) ? 2047 : m_beat + LOOK - sb;
                m_dur[free]  = int'(e[10:0]);
            end
            m_ptr = (m_ptr + 1) % 1024;
            consumed++;
        end
    endtask

    task automatic m_start(output int consumed);
        for (int s = 0; s < SLOTS; s++) m_val[s] = 1'b0;
        m_beat = 0;
        m_ptr  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_admit(consumed);
    endtask

    task automatic m_tick(output int consumed);
        consumed = 0;
        if (!m_done) begin
            m_beat++;
            for (int s = 0; s < SLOTS; s++) begin
                if (m_val[s]) begin
                    if (m_ran[s] < 2047) m_ran[s]++;
                    if (m_ran[s] >= m_dur[s] + RET) m_val[s] = 1'b0;
                end
            end
            m_admit(consumed);
        end
    endtask

    task automatic compare_model(string tag);
        logic [27:0] exp;
        for (int s = 0; s < SLOTS; s++) begin
            exp = m_val[s] ? trip(m_note[s], m_ran[s], m_dur[s]) : 28'h0;
            chk($sformatf("%s slot%0d", tag, s), notes[s], exp);
        end
        chk({tag, " song_done"}, 28'(song_done), 28'(m_done));
        chk({tag, " overflow"}, 28'(overflow), 28'(m_ovf));
        chk({tag, " rom_addr"}, 28'(rom_addr), 28'(m_ptr));
    endtask

    task automatic build_song(int n);
        int b;
        rom_clear();
        b = 0;
        for (int i = 0; i < n; i++) begin
            b += $urandom_range(0, 30);
            rom_mem[i] = trip($urandom_range(0, 62), b, $urandom_range(0, 200));
        end
    endtask

    initial begin
        int cons;
        int live;
        int extra;

        // Single-note scenarios; entry 1 is a far-future blocker so aging never stops.
        vecs[0]  = '{5,   0, 48,   0, trip(5, 192, 48)};
        vecs[1]  = '{5,   0, 48,  10, trip(5, 202, 48)};
        vecs[2]  = '{3, 300, 10, 107, 28'h0};
        vecs[3]  = '{3, 300, 10, 108, trip(3, 0, 10)};
        vecs[4]  = '{3, 300, 10, 501, trip(3, 393, 10)};
        vecs[5]  = '{3, 300, 10, 502, 28'h0};
        vecs[6]  = '{1, 100,  0,   0, trip(1, 92, 0)};
        vecs[7]  = '{1, 100,  0, 291, trip(1, 383, 0)};
        vecs[8]  = '{1, 100,  0, 292, 28'h0};
        vecs[9]  = '{62, 192, 5,   0, trip(62, 0, 5)};
        vecs[10] = '{62, 193, 5,   0, 28'h0};
        vecs[11] = '{62, 193, 5,   1, trip(62, 0, 5)};

        rom_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset slot0", notes[0], 28'h0);
        chk("reset slot31", notes[31], 28'h0);
        chk("reset song_done", 28'(song_done), 28'h0);
        chk("reset overflow", 28'(overflow), 28'h0);
        chk("reset rom_addr", 28'(rom_addr), 28'h0);
        reset_n = 1'b1;
        $display("reset released");

        // ---- table-driven single-note vectors ----
        for (int v = 0; v < 12; v++) begin
            rom_clear();
            rom_mem[0] = trip(vecs[v].note, vecs[v].start_beat, vecs[v].dur);
            rom_mem[1] = trip(9, 2040, 1);
            pulse_start();
            repeat (20) @(posedge clk);
            for (int t = 0; t < vecs[v].ticks; t++) do_tick(8);
            @(negedge clk);
            chk($sformatf("vec%0d slot0", v), notes[0], vecs[v].exp0);
            chk($sformatf("vec%0d slot1", v), notes[1], 28'h0);
            chk($sformatf("vec%0d song_done", v), 28'(song_done), 28'h0);
            chk($sformatf("vec%0d overflow", v), 28'(overflow), 28'h0);
            $display("vec %0d: note %0d start %0d dur %0d ticks %0d slot0=%h",
                     v, vecs[v].note, vecs[v].start_beat, vecs[v].dur, vecs[v].ticks, notes[0]);
        end

        // ---- two-note song then end marker ----
        rom_clear();
        rom_mem[0] = trip(5, 0, 48);
        rom_mem[1] = trip(7, 48, 24);
        pulse_start();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("two slot0", notes[0], trip(5, 192, 48));
        chk("two slot1", notes[1], trip(7, 144, 24));
        chk("two slot2", notes[2], 28'h0);
        chk("two song_done", 28'(song_done), 28'h1);
        chk("two overflow", 28'(overflow), 28'h0);
        chk("two rom_addr", 28'(rom_addr), 28'd2);
        do_tick(8);
        @(negedge clk);
        chk("frozen slot0", notes[0], trip(5, 192, 48));
        $display("two-note song: slot0=%h slot1=%h done=%0d", notes[0], notes[1], song_done);

        // ---- asynchronous reset with live slots ----
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("areset slot0", notes[0], 28'h0);
        chk("areset slot1", notes[1], 28'h0);
        chk("areset song_done", 28'(song_done), 28'h0);
        chk("areset rom_addr", 28'(rom_addr), 28'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        $display("mid-song reset applied");

        // ---- 33 simultaneous entries, 32 slots ----
        rom_clear();
        for (int i = 0; i < 33; i++) rom_mem[i] = trip(i, 0, i + 1);
        pulse_start();
        repeat (100) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < SLOTS; i++)
            chk($sformatf("full slot%0d", i), notes[i], trip(i, 192, i + 1));
        chk("full overflow", 28'(overflow), 28'h1);
        chk("full rom_addr", 28'(rom_addr), 28'd33);
        chk("full song_done", 28'(song_done), 28'h1);
        $display("33 entries: overflow=%0d rom_addr=%0d", overflow, rom_addr);

        // ---- two ticks during one fetch burst ----
        rom_clear();
        rom_mem[0] = trip(1, 0, 10);
        rom_mem[1] = trip(2, 0, 10);
        rom_mem[2] = trip(3, 0, 10);
        rom_mem[3] = trip(4, 2040, 1);
        pulse_start();
        @(posedge clk); #1 beat_tick = 1'b1;
        @(posedge clk); #1 beat_tick = 1'b0;
        @(posedge clk); #1 beat_tick = 1'b1;
        @(posedge clk); #1 beat_tick = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("burst slot0", notes[0], trip(1, 193, 10));
        chk("burst slot2", notes[2], trip(3, 193, 10));
        chk("burst slot3", notes[3], 28'h0);
        chk("burst overflow", 28'(overflow), 28'h1);
        $display("tick burst: slot0=%h overflow=%0d", notes[0], overflow);

        // ---- start while in CHECK with 3 live slots and a pending tick ----
        rom_clear();
        rom_mem[0] = trip(1, 0, 10);
        rom_mem[1] = trip(2, 0, 10);
        rom_mem[2] = trip(3, 0, 10);
        rom_mem[3] = trip(4, 0, 10);
        rom_mem[4] = trip(5, 2040, 1);
        pulse_start();
        @(posedge clk); #1 beat_tick = 1'b1;
        @(posedge clk); #1 beat_tick = 1'b0;
        @(posedge clk); #1 beat_tick = 1'b1;
        @(posedge clk); #1 beat_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort pre rom_addr", 28'(rom_addr), 28'd3);
        chk("abort pre slot2", notes[2], trip(3, 192, 10));
        chk("abort pre slot3", notes[3], 28'h0);
        chk("abort pre overflow", 28'(overflow), 28'h1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("abort slot%0d", i), notes[i], 28'h0);
        chk("abort rom_addr", 28'(rom_addr), 28'h0);
        chk("abort overflow", 28'(overflow), 28'h0);
        chk("abort song_done", 28'(song_done), 28'h0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("refetch slot0", notes[0], trip(1, 192, 10));
        chk("refetch slot3", notes[3], trip(4, 192, 10));
        chk("refetch slot4", notes[4], 28'h0);
        chk("refetch overflow", 28'(overflow), 28'h0);
        $display("abort in CHECK: refetched slot3=%h", notes[3]);

        // ---- random songs against the model ----
        for (int song = 0; song < 2; song++) begin
            build_song(30);
            m_start(cons);
            pulse_start();
            repeat (12 + 2 * cons) @(posedge clk);
            @(negedge clk);
            compare_model($sformatf("song%0d start", song));
            extra = 0;
            for (int t = 0; t < 400; t++) begin
                if (m_done) extra++;
                if (extra > 3) break;
                m_tick(cons);
                do_tick(6 + 2 * cons);
                @(negedge clk);
                compare_model($sformatf("song%0d tick%0d", song, t));
                live = 0;
                for (int s = 0; s < SLOTS; s++) if (m_val[s]) live++;
                $display("song %0d tick %0d: beat %0d live %0d done %0d ovf %0d",
                         song, t, m_beat, live, m_done, m_ovf);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
